prio_enc_scan: RTL and testbench
================================

# prio_enc_scan

Parametrised, clocked successor to the cascaded 74HC148 / 74HC4511 priority-encoder display path. It monitors `CH` active-low request lines and synchronises them. It debounces the encoded result, registers the highest-index active channel, and drives a two-digit multiplexed 7-segment display showing that index in decimal, 0..99. It sits between the board request inputs (keys/interrupt lines) and the display pins, replacing the single-digit, blank-above-9 combinational path.

## Interface
- `CH`, default 16: number of request channels, legal range 2..100.
- `DEB_CYC`, default 4: consecutive identical encoder samples required to commit, ≥1.
- `SCAN_DIV`, default 1000: clock cycles each digit is displayed, ≥2.
- `IW`: derived, `$clog2(CH)`; it is not overridable.

Ports:
- `clk`  in  1: the single system clock; all logic is on the rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `ei_n`  in  1: enable input, active-low, 74HC148 sense; asynchronous to `clk`.
- `din_n`  in  CH: request lines, active-low; `din_n[i]` is channel i; asynchronous.
- `clr`  in  1: synchronous pulse that clears the held code; used only with the latch feature.
- `code`  out  IW: registered index of the committed channel.
- `valid`  out  1: `code` holds a live channel.
- `gs_n`  out  1: group select, equal to `~valid`.
- `eo_n`  out  1: low when enabled and no debounced request is active.
- `seg`  out  8: segments `{dp,g,f,e,d,c,b,a}`, active-high; `dp` is always 0.
- `dig_n`  out  2: digit enables, active-low; bit 0 is units, bit 1 is tens.

## Operation
- **Synchroniser.** Two flops per bit on `din_n` and `ei_n`. The flops reset to 1 (inactive).
- **Encoder.** Combinational on the synchronised lines. If synchronised `ei_n` is 1, or no line is low, the encoder gives "none". Otherwise it gives the highest i with `din_n[i]` low.
- **Debounce FSM**, with states IDLE, COUNT and STABLE:
  - The candidate register `{present, idx}` and counter `cnt` are compared against the encoder output every cycle.
  - If the encoder output differs from the candidate: load the candidate, set `cnt` = 0, go to COUNT.
  - If it is equal and `cnt` < DEB_CYC-1: increment `cnt`.
  - If it is equal and `cnt` == DEB_CYC-1 in COUNT: commit the candidate to the debounced register and go to STABLE.
  - STABLE holds until the encoder output differs.
  - IDLE is entered from reset with the candidate set to "none".
- **Outputs (non-latch).**
  - `valid`/`code` equal the debounced register; `code` = 0 whenever `valid` = 0.
  - `eo_n` = 0 iff synchronised `ei_n` = 0 and the debounced value is "none".
- **Display scan.**
  - Counter 0..SCAN_DIV-1. On wrap, the digit select toggles, and `dig_n` and `seg` update on that same edge.
  - Tens = `code`/10 and units = `code`%10; values are 0..99 by the `CH` limit.
  - `seg` is 0 (blank) when `valid` = 0, and on the tens digit when tens = 0 (leading-zero blanking).
  - Digit patterns, hex: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
- **Reset mid-operation.** All state returns to reset values on the edge that samples `rst_n` = 0. Any partially counted candidate is discarded.

## Timing
- Reset values:
  - `code` = 0, `valid` = 0, `gs_n` = 1, `eo_n` = 1.
  - `seg` = 8'h00, `dig_n` = 2'b10 (units digit selected), scan counter 0.
  - FSM in IDLE.
- **Commit latency.** An input change set up before edge 1 updates `valid`/`code`/`gs_n` on edge DEB_CYC+3, if the input is held. Example: DEB_CYC=4 gives edge 7.
- **Glitches.** A change held for fewer than DEB_CYC+1 edges produces no output change.
- **`eo_n`** updates on the same edge as `valid`.
- **Display latency.** `seg` reflects a new `code` at the next scan edge at most: at most SCAN_DIV cycles later.
- **Simultaneous requests.** The highest index always wins. A lower-index press during a held higher-index press is invisible.

## Configuration
- Macro `PRIO_ENC_LATCH_EN` compiles the latch feature in or out.
- **Defined (sticky latch).**
  - The first commit of a non-"none" value loads the hold register. It stays loaded after the request is released.
  - A later commit of a strictly higher index replaces it. Lower indices and "none" are ignored.
  - `clr` = 1 empties the hold register on that edge (`valid` → 0, `code` → 0). `clr` has priority over a commit on the same edge.
  - If a request is still debounced-active after `clr`, the hold reloads on the following edge.
  - `eo_n` uses the hold register in place of the debounced value.
- **Undefined.** `clr` is ignored and outputs follow the debounced value directly.

## Test plan
1. **Reset.** `rst_n` = 0 for 3 edges with random inputs. Required: `code` = 0, `valid` = 0, `gs_n` = 1, `eo_n` = 1, `seg` = 00, `dig_n` = 10.
2. **Priority and two-digit display.** CH=16, DEB_CYC=4, `ei_n` = 0; `din_n[5]` and `din_n[12]` low and held. Required: at edge 7, `code` = 12, `valid` = 1, `gs_n` = 0, `eo_n` = 1. Units digit shows `seg` = 5B; tens digit shows `seg` = 06.
3. **Glitch rejection.** `din_n[3]` low for 3 edges, then high. Required: `valid` stays 0 and `eo_n` stays 0 throughout.
4. **Enable gating and leading-zero blanking.**
   - `din_n[7]` low with `ei_n` = 1. Required: `valid` = 0, `eo_n` = 1.
   - Drop `ei_n` to 0. Required: `code` = 7 at edge 7; tens `seg` = 00, units `seg` = 07.
5. **Latch feature** (`PRIO_ENC_LATCH_EN` defined). Press channel 9, then release.
   - Required: `code` = 9 and `valid` = 1 are held; units `seg` = 6F.
   - Press channel 4. Required: no change.
   - Pulse `clr`. Required: `valid` = 0 on that edge.
6. **Reset mid-debounce.** Press channel 2 and assert `rst_n` = 0 at edge 4, then release reset with channel 2 held. Required: commit occurs DEB_CYC+3 edges after reset release, not earlier.

Source files
------------

// File: rtl/prio_enc_scan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : prio_enc_scan                                                 |
// | Brief    : Synchronised, debounced priority encoder driving a two-digit  |
// |            multiplexed 7-segment display. Define PRIO_ENC_LATCH_EN to    |
// |            build in the sticky-latch hold register.                      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module prio_enc_scan #(
   parameter  int CH       = 16,
   parameter  int DEB_CYC  = 4,
   parameter  int SCAN_DIV = 1000,
   localparam int IW       = $clog2(CH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ei_n,
   input  logic [CH-1:0] din_n,
   input  logic          clr,
   output logic [IW-1:0] code,
   output logic          valid,
   output logic          gs_n,
   output logic          eo_n,
   output logic [7:0]    seg,
   output logic [1:0]    dig_n
);

   localparam int            CW          = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
   localparam int            SW          = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] C_CNT_LAST  = CW'(DEB_CYC - 1);
   localparam logic [SW-1:0] C_SCAN_LAST = SW'(SCAN_DIV - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_COUNT  = 2'd1,
      ST_STABLE = 2'd2
   } state_t;

   logic [CH-1:0] r_din_s1;
   logic [CH-1:0] r_din_s2;
   logic          r_ei_s1;
   logic          r_ei_s2;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_din_s1 <= '1;
         r_din_s2 <= '1;
         r_ei_s1  <= 1'b1;
         r_ei_s2  <= 1'b1;
      end else begin
         r_din_s1 <= din_n;
         r_din_s2 <= r_din_s1;
         r_ei_s1  <= ei_n;
         r_ei_s2  <= r_ei_s1;
      end
   end

   logic          w_enc_pres;
   logic [IW-1:0] w_enc_idx;

   // Ascending scan so the highest active index is the last one written.
   always_comb begin
      w_enc_pres = 1'b0;
      w_enc_idx  = '0;
      if (!r_ei_s2) begin
         for (int i = 0; i < CH; i++) begin
            if (!r_din_s2[i]) begin
               w_enc_pres = 1'b1;
               w_enc_idx  = IW'(i);
            end
         end
      end
   end

   state_t        r_state;
   logic          r_cand_pres;
   logic [IW-1:0] r_cand_idx;
   logic [CW-1:0] r_cnt;
   logic          r_deb_pres;
   logic [IW-1:0] r_deb_idx;
   logic          w_match;
   logic          w_commit;

   assign w_match  = (w_enc_pres == r_cand_pres) && (w_enc_idx == r_cand_idx);
   assign w_commit = (r_state == ST_COUNT) && w_match && (r_cnt == C_CNT_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_cand_pres <= 1'b0;
         r_cand_idx  <= '0;
         r_cnt       <= '0;
         r_deb_pres  <= 1'b0;
         r_deb_idx   <= '0;
      end else if (!w_match) begin
         r_cand_pres <= w_enc_pres;
         r_cand_idx  <= w_enc_idx;
         r_cnt       <= '0;
         r_state     <= ST_COUNT;
      end else if (w_commit) begin
         r_deb_pres  <= r_cand_pres;
         r_deb_idx   <= r_cand_idx;
         r_state     <= ST_STABLE;
      end else if (r_state == ST_COUNT) begin
         r_cnt       <= r_cnt + 1'b1;
      end
   end

   logic          w_out_pres;
   logic [IW-1:0] w_out_idx;

`ifdef PRIO_ENC_LATCH_EN
   logic          w_deb_pres_nxt;
   logic [IW-1:0] w_deb_idx_nxt;
   logic          r_hold_pres;
   logic [IW-1:0] r_hold_idx;

   // Looking at the next debounced value lets the hold load on the commit
   // edge itself, and reload one edge after clr if a request is still up.
   assign w_deb_pres_nxt = w_commit ? r_cand_pres : r_deb_pres;
   assign w_deb_idx_nxt  = w_commit ? r_cand_idx  : r_deb_idx;

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         r_hold_pres <= 1'b0;
         r_hold_idx  <= '0;
      end else if (w_deb_pres_nxt && (!r_hold_pres || (w_deb_idx_nxt > r_hold_idx))) begin
         r_hold_pres <= 1'b1;
         r_hold_idx  <= w_deb_idx_nxt;
      end
   end

   assign w_out_pres = r_hold_pres;
   assign w_out_idx  = r_hold_idx;
`else
   logic w_unused_clr;

   assign w_unused_clr = clr;
   assign w_out_pres   = r_deb_pres;
   assign w_out_idx    = r_deb_idx;
`endif

   assign valid = w_out_pres;
   assign code  = w_out_pres ? w_out_idx : '0;
   assign gs_n  = ~w_out_pres;
   assign eo_n  = r_ei_s2 | w_out_pres;

   logic [6:0] w_code_ext;
   logic [3:0] w_tens;
   logic [3:0] w_units;

   assign w_code_ext = 7'(code);
   assign w_tens     = 4'(w_code_ext / 7'd10);
   assign w_units    = 4'(w_code_ext % 7'd10);

   function automatic logic [7:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0:    seg_of = 8'h3F;
         4'd1:    seg_of = 8'h06;
         4'd2:    seg_of = 8'h5B;
         4'd3:    seg_of = 8'h4F;
         4'd4:    seg_of = 8'h66;
         4'd5:    seg_of = 8'h6D;
         4'd6:    seg_of = 8'h7D;
         4'd7:    seg_of = 8'h07;
         4'd8:    seg_of = 8'h7F;
         4'd9:    seg_of = 8'h6F;
         default: seg_of = 8'h00;
      endcase
   endfunction

   logic [SW-1:0] r_scan_cnt;
   logic          r_dig_sel;
   logic [7:0]    r_seg;
   logic [1:0]    r_dig_n;

   // r_dig_sel is the digit currently shown: 0 = units, 1 = tens.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_scan_cnt <= '0;
         r_dig_sel  <= 1'b0;
         r_seg      <= 8'h00;
         r_dig_n    <= 2'b10;
      end else if (r_scan_cnt == C_SCAN_LAST) begin
         r_scan_cnt <= '0;
         r_dig_sel  <= ~r_dig_sel;
         if (!r_dig_sel) begin
            r_dig_n <= 2'b01;
            r_seg   <= (w_out_pres && (w_tens != 4'd0)) ? seg_of(w_tens) : 8'h00;
         end else begin
            r_dig_n <= 2'b10;
            r_seg   <= w_out_pres ? seg_of(w_units) : 8'h00;
         end
      end else begin
         r_scan_cnt <= r_scan_cnt + 1'b1;
      end
   end

   assign seg   = r_seg;
   assign dig_n = r_dig_n;

endmodule
`default_nettype wire

// File: tb/tb_prio_enc_scan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_prio_enc_scan                                              |
// | Brief    : Directed self-checking bench for prio_enc_scan (CH=16,        |
// |            DEB_CYC=4, SCAN_DIV=4); PRIO_ENC_LATCH_EN selects latch cases.|
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_prio_enc_scan;

   localparam int CH  = 16;
   localparam int DEB = 4;
   localparam int SD  = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ei_n;
   logic [15:0] din_n;
   logic        clr;
   logic [3:0]  code;
   logic        valid;
   logic        gs_n;
   logic        eo_n;
   logic [7:0]  seg;
   logic [1:0]  dig_n;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   prio_enc_scan #(
      .CH       (CH),
      .DEB_CYC  (DEB),
      .SCAN_DIV (SD)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ei_n  (ei_n),
      .din_n (din_n),
      .clr   (clr),
      .code  (code),
      .valid (valid),
      .gs_n  (gs_n),
      .eo_n  (eo_n),
      .seg   (seg),
      .dig_n (dig_n)
   );

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Let both digits refresh, then wait (bounded) for the wanted digit.
   task automatic check_digit(input string tag, input logic [1:0] want, input logic [7:0] exp_seg);
      int k;
      tick(2 * SD);
      k = 0;
      while (dig_n !== want && k < 2 * SD + 2) begin
         tick();
         k++;
      end
      chk({tag, "_dig"}, 32'(dig_n), 32'(want));
      chk(tag, 32'(seg), 32'(exp_seg));
   endtask

   task automatic settle();
      din_n = 16'hFFFF;
      tick(10);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      tick(2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset with random inputs
      rst_n = 1'b0;
      ei_n  = 1'($urandom);
      din_n = 16'($urandom);
      clr   = 1'($urandom);
      tick();
      din_n = 16'($urandom);
      ei_n  = 1'($urandom);
      tick();
      din_n = 16'($urandom);
      tick();
      chk("rst_code",  32'(code),  32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_gs_n",  32'(gs_n),  32'd1);
      chk("rst_eo_n",  32'(eo_n),  32'd1);
      chk("rst_seg",   32'(seg),   32'h00);
      chk("rst_dig_n", 32'(dig_n), 32'b10);

      // Priority: channels 5 and 12 together, 12 wins
      din_n     = 16'hFFFF;
      din_n[5]  = 1'b0;
      din_n[12] = 1'b0;
      ei_n      = 1'b0;
      clr       = 1'b0;
      rst_n     = 1'b1;
      tick(3);
      chk("scan_hold", 32'(dig_n), 32'b10);
      tick();
      chk("scan_wrap", 32'(dig_n), 32'b01);
      chk("scan_blank_invalid", 32'(seg), 32'h00);
      tick(2);
      chk("prio_early_valid", 32'(valid), 32'd0);
      chk("prio_early_eo_n",  32'(eo_n),  32'd0);
      tick();
      chk("prio_code",  32'(code),  32'd12);
      chk("prio_valid", 32'(valid), 32'd1);
      chk("prio_gs_n",  32'(gs_n),  32'd0);
      chk("prio_eo_n",  32'(eo_n),  32'd1);
      check_digit("prio_units", 2'b10, 8'h5B);
      check_digit("prio_tens",  2'b01, 8'h06);

      // Glitch rejection: 3 and 4 edges are too short, 5 commits
      settle();
      chk("idle_valid", 32'(valid), 32'd0);
      chk("idle_eo_n",  32'(eo_n),  32'd0);
      din_n[3] = 1'b0;
      tick(3);
      din_n[3] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("glitch3_valid", 32'(valid), 32'd0);
         chk("glitch3_eo_n",  32'(eo_n),  32'd0);
      end
      din_n[3] = 1'b0;
      tick(4);
      din_n[3] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("glitch4_valid", 32'(valid), 32'd0);
      end
      din_n[3] = 1'b0;
      tick(5);
      din_n[3] = 1'b1;
      tick();
      chk("hold5_early_valid", 32'(valid), 32'd0);
      tick();
      chk("hold5_valid", 32'(valid), 32'd1);
      chk("hold5_code",  32'(code),  32'd3);

      // Enable gating and leading-zero blanking
      settle();
      din_n[7] = 1'b0;
      ei_n     = 1'b1;
      tick(8);
      chk("ei_off_valid", 32'(valid), 32'd0);
      chk("ei_off_eo_n",  32'(eo_n),  32'd1);
      ei_n = 1'b0;
      tick(6);
      chk("ei_on_early_valid", 32'(valid), 32'd0);
      chk("ei_on_early_eo_n",  32'(eo_n),  32'd0);
      tick();
      chk("ei_on_code",  32'(code),  32'd7);
      chk("ei_on_valid", 32'(valid), 32'd1);
      check_digit("lz_tens",  2'b01, 8'h00);
      check_digit("lz_units", 2'b10, 8'h07);

`ifdef PRIO_ENC_LATCH_EN
      // clr empties, then reloads because channel 7 is still held
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clr_valid", 32'(valid), 32'd0);
      chk("clr_code",  32'(code),  32'd0);
      tick();
      chk("clr_reload_code", 32'(code), 32'd7);

      settle();
      chk("latch_empty_valid", 32'(valid), 32'd0);
      din_n[9] = 1'b0;
      tick(7);
      chk("latch9_code", 32'(code), 32'd9);
      din_n = 16'hFFFF;
      tick(12);
      chk("latch9_held_code",  32'(code),  32'd9);
      chk("latch9_held_valid", 32'(valid), 32'd1);
      check_digit("latch9_units", 2'b10, 8'h6F);
      din_n[4] = 1'b0;
      tick(12);
      chk("latch_low_ignored", 32'(code), 32'd9);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("latch_clr_valid", 32'(valid), 32'd0);
      tick();
      chk("latch_reload4_code", 32'(code), 32'd4);
`else
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clr_ignored_valid", 32'(valid), 32'd1);
      chk("clr_ignored_code",  32'(code),  32'd7);
`endif

      // Reset in the middle of a debounce
      settle();
      din_n[2] = 1'b0;
      tick(3);
      rst_n = 1'b0;
      tick();
      chk("midrst_valid", 32'(valid), 32'd0);
      chk("midrst_dig_n", 32'(dig_n), 32'b10);
      tick();
      rst_n = 1'b1;
      tick(6);
      chk("midrst_no_early", 32'(valid), 32'd0);
      tick();
      chk("midrst_valid_commit", 32'(valid), 32'd1);
      chk("midrst_code",         32'(code),  32'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
